aes_key_expand: RTL and testbench
=================================

# aes_key_expand

Iterative AES-128 key-schedule generator: takes the 128-bit cipher key and produces round keys 1–10, one per clock, as a valid-qualified stream with a start/finish handshake. Sits directly upstream of the round-key consumer (`newkey`/round stages) in the AES datapath, using the same byte packing and handshake style so its output can be fed straight in.

## Interface
- `NROUNDS`, default 10: number of round keys generated. Fixed at 10 for AES-128; other values are out of scope.
- `clk`  in  1  rising-edge clock, the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level request; held high for the whole run; low returns the block to idle.
- `key`  in  128  cipher key; byte 0 in bits [7:0], byte 15 in [127:120]; sampled only on the IDLE→RUN edge.
- `rkey`  out  128  current round key, same byte packing as `key`.
- `round`  out  4  index of the key on `rkey` (0 = cipher key, 1..10).
- `rkey_valid`  out  1  `rkey`/`round` carry round key 1..10 this cycle.
- `finish`  out  1  all round keys produced; held while `start` stays high.

## Operation
- Words: w0 = bits [31:0] … w3 = [127:96]; word byte 0 = its bits [7:0].
- Per round r (1..10): t = SubWord(RotWord(w3)) ^ {24'h0, rcon[r]}; RotWord moves byte 0 to byte 3 (w >> 8 | w[7:0] << 24); rcon = 01,02,04,08,10,20,40,80,1b,36 in bits [7:0]. n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
- FSM, registered state:
  - IDLE: outputs cleared. `start`=1 → capture `key` into `rkey`, `round`<=0, → RUN.
  - RUN: each edge `rkey`<=next(rkey), `round`++, `rkey_valid`<=1. When the update writes round 10 → DONE with `finish`<=1 on the same edge. `start`=0 → IDLE (abort).
  - DONE: `rkey`=round 10 key held, `round`=10, `rkey_valid`=0, `finish`=1. `start`=0 → IDLE.
- IDLE outputs: `rkey`=0, `round`=0, `rkey_valid`=0, `finish`=0.
- Reset wins over everything: any state → IDLE, all outputs 0 after the edge; mid-run reset discards progress.
- `key` changes after capture are ignored until the next IDLE→RUN.
- Restart requires `start` low for ≥1 edge (pass through IDLE); no back-to-back run without it.

## Timing
- Edge E0: `start` sampled high in IDLE. After E0: `round`=0, `rkey`=key, `rkey_valid`=0.
- After edge E0+k (k=1..10): `round`=k, `rkey`=round key k, `rkey_valid`=1.
- After E0+10: `finish`=1 (coincides with round 10 valid); after E0+11: `rkey_valid`=0, `finish`=1 held.
- `start` low sampled at edge Ex: outputs cleared after Ex (1-cycle response), in RUN or DONE.
- One S-box stage per round (4 lookups combinational, one cycle); no multicycle paths.

## Structure
- Package `aes_pkg`: FSM state enum (IDLE, RUN, DONE), `rcon` constant array [1:10], 128-bit/32-bit word typedefs, sbox function or table shared with the cipher round stages.
- Sub-module `aes_sbox`: combinational 8-bit S-box, instantiated 4× for SubWord; reused later by SubBytes.

## Test plan
- FIPS-197 key 128'h3c4fcf098815f7aba6d2ae2816157e2b → round 1 128'h05766c2a3939a323b12c548817fefaa0, round 2 128'h7ff659737a80355943b9967af295c2f2, round 10 128'ha60c63b6c80c3fe18925eec9a8f914d0 with `finish` rising on that cycle.
- All-zero key → round 1 128'h63636362636363626363636263636362, round 10 128'h8e188f6fcf51e92311e2923ecb5befb4.
- Cycle check: `rkey_valid` high exactly 10 consecutive cycles, `round` 1..10 in order, starting the cycle after `start` first sampled high.
- Abort: drop `start` after round 4 → next cycle all outputs 0, state IDLE; raise again → full correct sequence from round 1.
- Hold/release: `start` held 20 cycles past finish → `rkey`/`finish` stable, `rkey_valid` 0; drop `start` → `finish` low next cycle.
- Reset mid-run (round 6) → all outputs 0 next cycle; `key` changed during RUN has no effect on the in-progress sequence.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, round constants and S-box table
// Purpose: FSM state enum, word/block typedefs, rcon table and the byte
//          S-box lookup used by key expansion and the cipher round stages.
// Ports:   none (package).
package aes_pkg;

   typedef logic [31:0]  word_t;
   typedef logic [127:0] block_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   // Round constant for round r; rounds outside 1..10 get zero so the
   // combinational next-key path never reads outside the table.
   function automatic logic [7:0] rcon_of(input logic [3:0] r);
      if (r >= 4'd1 && r <= 4'd10)
         return RCON[r];
      return 8'h00;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES byte S-box
// Purpose: single forward S-box lookup, shared by SubWord and SubBytes.
// Ports:   a - input byte; y - substituted byte.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] y
);

   assign y = sbox(a);

endmodule

// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - iterative AES-128 key schedule, one round key per clock
// Purpose: captures the cipher key when start rises and streams round keys
//          1..NROUNDS, then holds the last key with finish until start drops.
// Ports:   clk, rst (sync, active-high); start (level run request);
//          key (cipher key, byte 0 in [7:0]); rkey (current round key);
//          round (index of rkey); rkey_valid (rkey is a fresh round key 1..10);
//          finish (all round keys produced, held while start stays high).
module aes_key_expand
   import aes_pkg::*;
#(
   parameter int NROUNDS = 10
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key,
   output logic [127:0] rkey,
   output logic [3:0]   round,
   output logic         rkey_valid,
   output logic         finish
);

   localparam logic [3:0] LAST_PREV = 4'(NROUNDS - 1);

   state_t state;

   word_t  w0, w1, w2, w3;
   word_t  rot, sub, t;
   word_t  n0, n1, n2, n3;
   block_t next_key;
   logic [3:0] round_next;

   assign w0 = rkey[31:0];
   assign w1 = rkey[63:32];
   assign w2 = rkey[95:64];
   assign w3 = rkey[127:96];

   // RotWord: byte 0 moves to byte 3.
   assign rot = {w3[7:0], w3[31:8]};

   for (genvar i = 0; i < 4; i++) begin : g_subword
      aes_sbox u_sbox (
         .a (rot[8*i +: 8]),
         .y (sub[8*i +: 8])
      );
   end

   assign round_next = round + 4'd1;
   assign t  = sub ^ {24'h0, rcon_of(round_next)};
   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;
   assign next_key = {n3, n2, n1, n0};

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rkey       <= '0;
         round      <= '0;
         rkey_valid <= 1'b0;
         finish     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               rkey_valid <= 1'b0;
               finish     <= 1'b0;
               round      <= '0;
               if (start) begin
                  rkey  <= key;
                  state <= RUN;
               end else begin
                  rkey  <= '0;
               end
            end
            RUN: begin
               if (!start) begin
                  state      <= IDLE;
                  rkey       <= '0;
                  round      <= '0;
                  rkey_valid <= 1'b0;
                  finish     <= 1'b0;
               end else begin
                  rkey       <= next_key;
                  round      <= round_next;
                  rkey_valid <= 1'b1;
                  // finish rises together with the last valid round key
                  if (round == LAST_PREV) begin
                     finish <= 1'b1;
                     state  <= DONE;
                  end
               end
            end
            DONE: begin
               rkey_valid <= 1'b0;
               if (!start) begin
                  state  <= IDLE;
                  rkey   <= '0;
                  round  <= '0;
                  finish <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               rkey       <= '0;
               round      <= '0;
               rkey_valid <= 1'b0;
               finish     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_key_expand.sv
// tb/tb_aes_key_expand.sv - directed self-checking bench for aes_key_expand
module tb_aes_key_expand;

   localparam logic [127:0] FIPS_KEY = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
   localparam logic [127:0] FIPS_R1  = 128'h05766c2a3939a323b12c548817fefaa0;
   localparam logic [127:0] FIPS_R2  = 128'h7ff659737a80355943b9967af295c2f2;
   localparam logic [127:0] FIPS_R10 = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
   localparam logic [127:0] ZERO_R1  = 128'h63636362636363626363636263636362;
   localparam logic [127:0] ZERO_R10 = 128'h8e188f6fcf51e92311e2923ecb5befb4;

   logic         clk;
   logic         rst;
   logic         start;
   logic [127:0] key;
   logic [127:0] rkey;
   logic [3:0]   round;
   logic         rkey_valid;
   logic         finish;

   int errors;
   int checks;

   aes_key_expand #(.NROUNDS(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .key        (key),
      .rkey       (rkey),
      .round      (round),
      .rkey_valid (rkey_valid),
      .finish     (finish)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; outputs are then sampled 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; key = FIPS_KEY;
      step();
      checks++;
      if ({rkey, round, rkey_valid, finish} !== 134'h0) begin
         errors++;
         $display("FAIL reset_outputs: got rkey=%h round=%0d v=%b f=%b expected all 0",
                  rkey, round, rkey_valid, finish);
      end
      start = 1'b0;
      step();
      rst = 1'b0;
      step();
      checks++;
      if ({rkey, round, rkey_valid, finish} !== 134'h0) begin
         errors++;
         $display("FAIL idle_outputs: got rkey=%h round=%0d v=%b f=%b expected all 0",
                  rkey, round, rkey_valid, finish);
      end
   endtask

   task automatic test_fips_sequence();
      key = FIPS_KEY; start = 1'b1;
      step();
      checks++;
      if (rkey !== FIPS_KEY || round !== 4'd0 || rkey_valid !== 1'b0 || finish !== 1'b0) begin
         errors++;
         $display("FAIL fips_capture: got rkey=%h round=%0d v=%b f=%b expected key round 0 v=0 f=0",
                  rkey, round, rkey_valid, finish);
      end
      for (int k = 1; k <= 10; k++) begin
         step();
         checks++;
         if (rkey_valid !== 1'b1 || round !== 4'(k) || finish !== (k == 10)) begin
            errors++;
            $display("FAIL fips_cycle_%0d: got v=%b round=%0d f=%b expected v=1 round=%0d f=%b",
                     k, rkey_valid, round, finish, k, (k == 10));
         end
         if (k == 1 || k == 2 || k == 10) begin
            checks++;
            if (rkey !== (k == 1 ? FIPS_R1 : (k == 2 ? FIPS_R2 : FIPS_R10))) begin
               errors++;
               $display("FAIL fips_rkey_%0d: got %h expected %h", k, rkey,
                        (k == 1 ? FIPS_R1 : (k == 2 ? FIPS_R2 : FIPS_R10)));
            end
         end
      end
   endtask

   task automatic test_hold_release();
      for (int c = 0; c < 20; c++) begin
         step();
         checks++;
         if (rkey !== FIPS_R10 || round !== 4'd10 || rkey_valid !== 1'b0 || finish !== 1'b1) begin
            errors++;
            $display("FAIL hold_%0d: got rkey=%h round=%0d v=%b f=%b expected r10 key round 10 v=0 f=1",
                     c, rkey, round, rkey_valid, finish);
         end
      end
      start = 1'b0;
      step();
      checks++;
      if ({rkey, round, rkey_valid, finish} !== 134'h0) begin
         errors++;
         $display("FAIL release: got rkey=%h round=%0d v=%b f=%b expected all 0",
                  rkey, round, rkey_valid, finish);
      end
   endtask

   task automatic test_zero_key();
      key = 128'h0; start = 1'b1;
      step();
      for (int k = 1; k <= 10; k++) begin
         step();
         if (k == 1) begin
            checks++;
            if (rkey !== ZERO_R1) begin
               errors++;
               $display("FAIL zero_rkey_1: got %h expected %h", rkey, ZERO_R1);
            end
         end
      end
      checks++;
      if (rkey !== ZERO_R10 || finish !== 1'b1 || rkey_valid !== 1'b1) begin
         errors++;
         $display("FAIL zero_rkey_10: got %h f=%b v=%b expected %h f=1 v=1",
                  rkey, finish, rkey_valid, ZERO_R10);
      end
      start = 1'b0;
      step();
   endtask

   task automatic test_abort();
      key = FIPS_KEY; start = 1'b1;
      step();
      for (int k = 1; k <= 4; k++) step();
      checks++;
      if (round !== 4'd4 || rkey_valid !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre: got round=%0d v=%b expected round=4 v=1", round, rkey_valid);
      end
      start = 1'b0;
      step();
      checks++;
      if ({rkey, round, rkey_valid, finish} !== 134'h0) begin
         errors++;
         $display("FAIL abort_clear: got rkey=%h round=%0d v=%b f=%b expected all 0",
                  rkey, round, rkey_valid, finish);
      end
      start = 1'b1;
      step();
      for (int k = 1; k <= 10; k++) begin
         step();
         checks++;
         if (round !== 4'(k) || rkey_valid !== 1'b1) begin
            errors++;
            $display("FAIL restart_cycle_%0d: got round=%0d v=%b expected round=%0d v=1",
                     k, round, rkey_valid, k);
         end
         if (k == 1) begin
            checks++;
            if (rkey !== FIPS_R1) begin
               errors++;
               $display("FAIL restart_rkey_1: got %h expected %h", rkey, FIPS_R1);
            end
         end
      end
      checks++;
      if (rkey !== FIPS_R10 || finish !== 1'b1) begin
         errors++;
         $display("FAIL restart_rkey_10: got %h f=%b expected %h f=1", rkey, finish, FIPS_R10);
      end
      start = 1'b0;
      step();
   endtask

   task automatic test_key_change_and_reset();
      key = FIPS_KEY; start = 1'b1;
      step();
      key = 128'h0123456789abcdeffedcba9876543210;
      for (int k = 1; k <= 10; k++) step();
      checks++;
      if (rkey !== FIPS_R10 || finish !== 1'b1) begin
         errors++;
         $display("FAIL key_change_ignored: got %h f=%b expected %h f=1", rkey, finish, FIPS_R10);
      end
      start = 1'b0;
      step();
      key = FIPS_KEY; start = 1'b1;
      step();
      for (int k = 1; k <= 6; k++) step();
      checks++;
      if (round !== 4'd6 || rkey_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre: got round=%0d v=%b expected round=6 v=1", round, rkey_valid);
      end
      rst = 1'b1;
      step();
      checks++;
      if ({rkey, round, rkey_valid, finish} !== 134'h0) begin
         errors++;
         $display("FAIL reset_mid_run: got rkey=%h round=%0d v=%b f=%b expected all 0",
                  rkey, round, rkey_valid, finish);
      end
      rst = 1'b0; start = 1'b0;
      step();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1; start = 1'b0; key = '0;
      test_reset();
      test_fips_sequence();
      test_hold_release();
      test_zero_key();
      test_abort();
      test_key_change_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
